// File: rtl/bus_mux_pkg.sv
// Shared types and defaults for the bus_mux_seq slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_mux_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_SRC = 16;
    localparam int DEF_SEL_W   = 4;

    // Sequencer states: IDLE serves direct requests, SCAN walks a range,
    // DONE drains the final scan beat before signalling completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when a source index does not name an existing source.
    function automatic logic idx_oob(input int idx, input int num_src);
        return (idx >= num_src);
    endfunction

endpackage

// File: rtl/bus_mux_core.sv
// Combinational NUM_SRC:1 source selector over a flattened source bus.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; out-of-range indices return all zeros.
module bus_mux_core
    import bus_mux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         sel_dat
);

    // Pick the addressed source; no match (index too large) leaves zero.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                sel_dat = src_bus[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_mux_seq.sv
// Registered bus mux with direct-select and range-scan modes.
// Latency: 1 cycle from request/scan step to bus_valid.
// Backpressure: output register holds while bus_valid && !out_ready; requests then dropped, scans stall.
module bus_mux_seq
    import bus_mux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic                     Clk,
    input  logic                     Rstn,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         mux_sel,
    input  logic                     sel_valid,
    input  logic                     mode,
    input  logic                     scan_start,
    input  logic [SEL_W-1:0]         scan_first,
    input  logic [SEL_W-1:0]         scan_last,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         Bus_select,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         bus_src,
    output logic                     scan_busy,
    output logic                     scan_done,
    output logic                     sel_err
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [WIDTH-1:0]  dat_q, dat_d;
    logic              vld_q, vld_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              reg_free;
    logic [SEL_W-1:0]  core_sel;
    logic [WIDTH-1:0]  sel_dat;
    logic [SEL_W-1:0]  ptr_next;

    // The output register may take a new beat when empty or being drained.
    assign reg_free = !vld_q || out_ready;

    // Direct requests address the selector only in IDLE; otherwise the scan pointer does.
    assign core_sel = (state_q == ST_IDLE) ? mux_sel : ptr_q;

    // Scan pointer walks upward and wraps past the highest source.
    assign ptr_next = (int'(ptr_q) == NUM_SRC - 1) ? '0 : ptr_q + SEL_W'(1);

    bus_mux_core #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_core (
        .src_bus (src_bus),
        .sel     (core_sel),
        .sel_dat (sel_dat)
    );

    // Next-state and next-output decisions for the sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        src_d   = src_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reg_free) begin
                    vld_d = 1'b0;
                end
                if (mode && scan_start) begin
                    // Bounds are latched only here; a bad bound aborts the launch.
                    if (idx_oob(int'(scan_first), NUM_SRC) ||
                        idx_oob(int'(scan_last), NUM_SRC)) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = scan_first;
                        last_d  = scan_last;
                        state_d = ST_SCAN;
                    end
                end else if (!mode && sel_valid && reg_free) begin
                    dat_d = sel_dat;
                    src_d = mux_sel;
                    vld_d = 1'b1;
                    err_d = idx_oob(int'(mux_sel), NUM_SRC);
                end
            end
            ST_SCAN: begin
                if (reg_free) begin
                    dat_d = sel_dat;
                    src_d = ptr_q;
                    vld_d = 1'b1;
                    if (ptr_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_next;
                    end
                end
            end
            ST_DONE: begin
                // Completion is flagged only once the final beat has left.
                if (reg_free) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SCAN);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Bus_select = dat_q;
    assign bus_valid  = vld_q;
    assign bus_src    = src_q;
    assign scan_busy  = busy_q;
    assign scan_done  = done_q;
    assign sel_err    = err_q;

endmodule

// File: tb/tb_bus_mux_seq.sv
// Self-checking bench for bus_mux_seq (WIDTH=8, NUM_SRC=12).
// Latency: n/a.
// Backpressure: out_ready driven from tables, directed sequences and random stimulus.
module tb_bus_mux_seq;

    localparam int W  = 8;
    localparam int N  = 12;
    localparam int SW = 4;

    logic            Clk;
    logic            Rstn;
    logic [N*W-1:0]  src_bus;
    logic [SW-1:0]   mux_sel;
    logic            sel_valid;
    logic            mode;
    logic            scan_start;
    logic [SW-1:0]   scan_first;
    logic [SW-1:0]   scan_last;
    logic            out_ready;
    logic [W-1:0]    Bus_select;
    logic            bus_valid;
    logic [SW-1:0]   bus_src;
    logic            scan_busy;
    logic            scan_done;
    logic            sel_err;

    logic [W-1:0]    src [N];

    int n_tests = 0;
    int n_fail  = 0;

    bus_mux_seq #(.WIDTH(W), .NUM_SRC(N), .SEL_W(SW)) dut (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .src_bus    (src_bus),
        .mux_sel    (mux_sel),
        .sel_valid  (sel_valid),
        .mode       (mode),
        .scan_start (scan_start),
        .scan_first (scan_first),
        .scan_last  (scan_last),
        .out_ready  (out_ready),
        .Bus_select (Bus_select),
        .bus_valid  (bus_valid),
        .bus_src    (bus_src),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .sel_err    (sel_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < N; i++) src_bus[i*W +: W] = src[i];
    end

    // ---------------- reference model ----------------
    // A scan is modelled as a list of source indices still to be emitted.
    int          m_q[$];
    bit          m_in_scan;
    logic [W-1:0] m_dat;
    int          m_src;
    bit          m_vld, m_err, m_done, m_busy;

    task automatic model_reset();
        m_q.delete();
        m_in_scan = 0;
        m_dat = '0; m_src = 0;
        m_vld = 0; m_err = 0; m_done = 0; m_busy = 0;
    endtask

    task automatic model_capture(input int idx);
        m_src = idx;
        m_vld = 1;
        m_dat = (idx < N) ? src[idx] : '0;
        m_err = (idx >= N);
    endtask

    // Applies the rules for one rising edge using the inputs currently driven.
    task automatic model_step();
        bit free;
        int f, l, i;
        free = !m_vld || out_ready;
        m_err = 0;
        m_done = 0;
        f = int'(scan_first);
        l = int'(scan_last);
        if (m_in_scan) begin
            if (m_q.size() > 0) begin
                if (free) model_capture(m_q.pop_front());
            end else if (free) begin
                m_vld = 0; m_done = 1; m_in_scan = 0;
            end
        end else if (mode && scan_start) begin
            if (free) m_vld = 0;
            if (f >= N || l >= N) begin
                m_err = 1;
            end else begin
                m_q.delete();
                i = f;
                m_q.push_back(i);
                while (i != l) begin
                    i = (i + 1) % N;
                    m_q.push_back(i);
                end
                m_in_scan = 1;
            end
        end else if (!mode && sel_valid && free) begin
            model_capture(int'(mux_sel));
        end else if (free) begin
            m_vld = 0;
        end
        m_busy = m_in_scan && (m_q.size() > 0);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vld"},  bus_valid, m_vld);
        chk({tag, ".err"},  sel_err,   m_err);
        chk({tag, ".done"}, scan_done, m_done);
        chk({tag, ".busy"}, scan_busy, m_busy);
        if (m_vld) begin
            chk({tag, ".dat"}, Bus_select, m_dat);
            chk({tag, ".src"}, bus_src,    m_src);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 0; sel_valid = 0; mux_sel = '0; scan_start = 0;
        scan_first = '0; scan_last = '0; out_ready = 1;
    endtask

    task automatic fixed_sources();
        for (int i = 0; i < N; i++) src[i] = 8'hA0 + 8'(i);
    endtask

    // ---------------- direct-mode vector table ----------------
    typedef struct {
        logic          mode;
        logic          sv;
        logic [SW-1:0] sel;
        logic          rdy;
        logic          e_vld;
        logic [W-1:0]  e_dat;
        logic [SW-1:0] e_src;
        logic          e_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int dcnt;
        int exp_src[4];

        tbl[0] = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 8'hA5, 4'd5,  1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 8'hA3, 4'd3,  1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 8'h00, 4'd0,  1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'd13, 1'b1, 1'b1, 8'h00, 4'd13, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 8'h00, 4'd13, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'd11, 1'b1, 1'b1, 8'hAB, 4'd11, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 8'h00, 4'd12, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 8'h00, 4'd0,  1'b0};

        Rstn = 0;
        idle_inputs();
        fixed_sources();
        #12;
        chk("reset_outputs", {Bus_select, bus_valid, bus_src, scan_busy, scan_done, sel_err}, '0);
        @(posedge Clk); #1;
        Rstn = 1;

        // Direct-mode table
        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode; sel_valid = tbl[i].sv; mux_sel = tbl[i].sel;
            out_ready = tbl[i].rdy; scan_start = 0;
            tick();
            chk($sformatf("tbl%0d.vld", i), bus_valid, tbl[i].e_vld);
            chk($sformatf("tbl%0d.err", i), sel_err, tbl[i].e_err);
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d.dat", i), Bus_select, tbl[i].e_dat);
                chk($sformatf("tbl%0d.src", i), bus_src, tbl[i].e_src);
            end
        end

        // Backpressure: beat from source 5 holds while the source changes and requests arrive
        idle_inputs();
        mux_sel = 4'd5; sel_valid = 1;
        tick();
        chk("bp_capture", {Bus_select, bus_valid, 4'(bus_src)}, {8'hA5, 1'b1, 4'd5});
        out_ready = 0; mux_sel = 4'd3; sel_valid = 1; src[5] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), {Bus_select, bus_valid, 4'(bus_src)}, {8'hA5, 1'b1, 4'd5});
        end
        out_ready = 1; sel_valid = 0;
        tick();
        chk("bp_release_vld", bus_valid, 1'b0);
        src[5] = 8'hA5;

        // Wrapped scan 10..1
        exp_src = '{10, 11, 0, 1};
        idle_inputs();
        mode = 1; scan_start = 1; scan_first = 4'd10; scan_last = 4'd1;
        tick();
        scan_start = 0; scan_first = 4'd3; scan_last = 4'd3;
        chk("wscan_launch", {scan_busy, bus_valid}, 2'b10);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            dcnt += int'(scan_done);
            chk($sformatf("wscan_beat%0d", k),
                {bus_valid, 4'(bus_src), Bus_select, scan_busy},
                {1'b1, 4'(exp_src[k]), 8'hA0 + 8'(exp_src[k]), (k < 3) ? 1'b1 : 1'b0});
        end
        tick();
        chk("wscan_done", {scan_done, bus_valid}, 2'b10);
        tick();
        dcnt += int'(scan_done);
        chk("wscan_done_pulse_once", {scan_done, scan_busy}, 2'b00);
        chk("wscan_done_early", dcnt, 0);

        // Single-beat scan on source 7
        idle_inputs();
        mode = 1; scan_start = 1; scan_first = 4'd7; scan_last = 4'd7;
        tick();
        scan_start = 0;
        tick();
        chk("one_beat", {bus_valid, 4'(bus_src), Bus_select, scan_busy}, {1'b1, 4'd7, 8'hA7, 1'b0});
        tick();
        chk("one_beat_done", {scan_done, bus_valid}, 2'b10);
        tick();
        chk("one_beat_done_clr", scan_done, 1'b0);

        // Out-of-range scan bound is rejected at launch
        idle_inputs();
        mode = 1; scan_start = 1; scan_first = 4'd3; scan_last = 4'd12;
        tick();
        scan_start = 0;
        chk("scan_bound_err", {sel_err, scan_busy}, 2'b10);
        tick();
        chk("scan_bound_err_pulse", {sel_err, scan_busy, bus_valid}, 3'b000);

        // Reset mid-scan after two of four beats
        idle_inputs();
        mode = 1; scan_start = 1; scan_first = 4'd10; scan_last = 4'd1;
        tick();
        scan_start = 0;
        tick();
        tick();
        chk("mid_beat2", {bus_valid, 4'(bus_src)}, {1'b1, 4'd11});
        Rstn = 0;
        #1;
        chk("mid_reset_outputs", {Bus_select, bus_valid, bus_src, scan_busy, scan_done, sel_err}, '0);
        tick();
        Rstn = 1;
        idle_inputs();
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            dcnt += int'(scan_done) + int'(bus_valid);
        end
        chk("mid_reset_quiet", dcnt, 0);
        mux_sel = 4'd2; sel_valid = 1;
        tick();
        chk("mid_reset_idle_capture", {bus_valid, 4'(bus_src), Bus_select}, {1'b1, 4'd2, 8'hA2});

        // Randomized run against the model
        Rstn = 0;
        idle_inputs();
        #1;
        model_reset();
        tick();
        Rstn = 1;
        for (int c = 0; c < 3000; c++) begin
            mode       = ($urandom % 2) == 0;
            sel_valid  = ($urandom % 2) == 0;
            mux_sel    = SW'($urandom_range(0, 15));
            scan_start = ($urandom % 6) == 0;
            scan_first = SW'($urandom_range(0, 12));
            scan_last  = SW'($urandom_range(0, 12));
            out_ready  = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) src[i] = W'($urandom);
            if (c % 1000 == 500) begin
                Rstn = 0;
                #1;
                model_reset();
                check_model("rand_rst");
                tick();
                Rstn = 1;
            end
            model_step();
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
